// File: rtl/digit_seq_pkg.sv
// -----------------------------------------------------------------------------
// digit_seq_pkg
//   Shared definitions for the digit sequencer and the display blocks that
//   reuse its hex decoder:
//     - state_t   : sequencer FSM states (ST_GAP only reachable when
//                   DIGIT_SEQ_BLANK_GAP_EN is defined)
//     - SEG_A/SEG_G/SEG_W : segment bit order (bit0 = a .. bit6 = g)
//     - SEG_TABLE : 16-entry hex to active-high 7-segment table
// -----------------------------------------------------------------------------
package digit_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EMIT  = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Segment a lives in bit 0, segment g in bit 6.
    localparam int SEG_A = 0;
    localparam int SEG_G = 6;
    localparam int SEG_W = SEG_G - SEG_A + 1;

    // Packed so that SEG_TABLE[d] is the code for digit d; the list is
    // therefore written from F down to 0.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/digit_sequencer_hex_to_7seg.sv
// -----------------------------------------------------------------------------
// hex_to_7seg
//   Purely combinational hex digit to 7-segment decoder.
//   Ports:
//     i_hex [3:0]       : hex digit 0x0..0xF
//     o_seg [SEG_W-1:0] : active-high segments, bit0 = a .. bit6 = g
// -----------------------------------------------------------------------------
module hex_to_7seg
    import digit_seq_pkg::*;
(
    input  logic [3:0]       i_hex,
    output logic [SEG_W-1:0] o_seg
);

    assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/digit_sequencer.sv
// -----------------------------------------------------------------------------
// digit_sequencer
//   Holds a DEPTH-entry buffer of hex digits and plays slots 0..msg_last back
//   one at a time. Each digit is decoded to 7 segments, presented on char_out
//   with a one-cycle char_available strobe, then held for HOLD_TICKS rising
//   edges of the 60 Hz clk60 input before the next digit. Single-shot or
//   looping playback.
//
//   Optional build macro: DIGIT_SEQ_BLANK_GAP_EN
//     When defined, every digit is followed by a blank (char_out = 0, with its
//     own strobe) held for max(HOLD_TICKS/4, 1) clk60 edges before advancing.
//
//   Ports:
//     clk, rst_n      : system clock, asynchronous active-low reset
//     enable          : when low every register (incl. clk60 edge detect) holds
//     clk60           : 60 Hz square wave, edge-detected against clk
//     wr_en/wr_addr/wr_data : buffer write, accepted only while idle
//     msg_last        : index of the last slot played
//     start / stop    : level controls; stop wins over start and advance
//     loop            : sampled at each wrap; 1 restarts from slot 0
//     char_available  : one-cycle strobe, new code on char_out
//     char_out        : 7-segment code, bit0 = a .. bit6 = g
//     busy            : FSM not idle
//     char_index      : slot currently displayed
//     dbg_state       : current FSM state encoding (state_t)
//
//   Handshake: char_available is a push-only strobe with no back-pressure;
//   char_out is stable from the strobe until the next EMIT, so a consumer may
//   sample it on the strobe cycle or any later cycle.
// -----------------------------------------------------------------------------
module digit_sequencer
    import digit_seq_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int IDX_W      = 3,
    parameter int HOLD_TICKS = 30
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clk60,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [3:0]       wr_data,
    input  logic [IDX_W-1:0] msg_last,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    output logic             char_available,
    output logic [6:0]       char_out,
    output logic             busy,
    output logic [IDX_W-1:0] char_index,
    output logic [2:0]       dbg_state
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_TICKS);
`ifdef DIGIT_SEQ_BLANK_GAP_EN
    localparam int         GAP_RAW  = HOLD_TICKS / 4;
    localparam logic [7:0] GAP_LOAD = (GAP_RAW < 1) ? 8'd1 : 8'(GAP_RAW);
`endif

    // ---------------------------------------------------------------- state
    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_hold_cnt;
    logic             r_clk60_prev;
    logic [3:0]       r_buf [DEPTH];
    logic             r_char_available;
    logic [6:0]       r_char_out;
    logic [IDX_W-1:0] r_char_index;

    // ---------------------------------------------------------------- wires
    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [7:0]       w_cnt_nxt;
    logic             w_load_code;
    logic             w_blank;
    logic             w_strobe;
    logic             w_wr_ok;
    logic             w_rise;
    state_t           w_adv_state;
    logic [IDX_W-1:0] w_adv_idx;
    logic [3:0]       w_cur_digit;
    logic [6:0]       w_seg;

    assign w_rise      = clk60 & ~r_clk60_prev;
    assign w_cur_digit = r_buf[r_idx];

    hex_to_7seg u_dec (
        .i_hex (w_cur_digit),
        .o_seg (w_seg)
    );

    // Advance decision, evaluated with the live msg_last and loop inputs so a
    // mid-play change takes effect at the next advance. An index already past
    // a newly shortened msg_last is treated as a wrap.
    always_comb begin
        w_adv_state = ST_IDLE;
        w_adv_idx   = r_idx;
        if (r_idx < msg_last) begin
            w_adv_state = ST_EMIT;
            w_adv_idx   = r_idx + 1'b1;
        end else if (loop) begin
            w_adv_state = ST_EMIT;
            w_adv_idx   = '0;
        end
    end

    // Next-state / datapath control.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_hold_cnt;
        w_load_code = 1'b0;
        w_blank     = 1'b0;
        w_strobe    = 1'b0;
        w_wr_ok     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_wr_ok = wr_en;
                if (start && !stop) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_EMIT;
                end
            end

            ST_EMIT: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_load_code = 1'b1;
                    w_strobe    = 1'b1;   // registered: high during PULSE
                    w_state_nxt = ST_PULSE;
                end
            end

            ST_PULSE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = HOLD_LOAD;
                    w_state_nxt = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_hold_cnt == 8'd0) begin
`ifdef DIGIT_SEQ_BLANK_GAP_EN
                    w_blank     = 1'b1;
                    w_strobe    = 1'b1;   // registered: high on first GAP cycle
                    w_cnt_nxt   = GAP_LOAD;
                    w_state_nxt = ST_GAP;
`else
                    w_idx_nxt   = w_adv_idx;
                    w_state_nxt = w_adv_state;
`endif
                end else if (w_rise) begin
                    w_cnt_nxt = r_hold_cnt - 8'd1;
                end
            end

`ifdef DIGIT_SEQ_BLANK_GAP_EN
            ST_GAP: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_hold_cnt == 8'd0) begin
                    w_idx_nxt   = w_adv_idx;
                    w_state_nxt = w_adv_state;
                end else if (w_rise) begin
                    w_cnt_nxt = r_hold_cnt - 8'd1;
                end
            end
`endif

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_idx            <= '0;
            r_hold_cnt       <= 8'd0;
            r_clk60_prev     <= 1'b0;
            r_char_available <= 1'b0;
            r_char_out       <= 7'h00;
            r_char_index     <= '0;
        end else if (enable) begin
            r_state          <= w_state_nxt;
            r_idx            <= w_idx_nxt;
            r_hold_cnt       <= w_cnt_nxt;
            r_clk60_prev     <= clk60;
            r_char_available <= w_strobe;
            if (w_load_code) begin
                r_char_out   <= w_seg;
                r_char_index <= r_idx;
            end else if (w_blank) begin
                r_char_out   <= 7'h00;
            end
        end
    end

    // Digit buffer; a write together with start commits on the same edge
    // that enters EMIT, so the first decode already sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= 4'h0;
            end
        end else if (enable && w_wr_ok) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    assign char_available = r_char_available;
    assign char_out       = r_char_out;
    assign char_index     = r_char_index;
    assign busy           = (r_state != ST_IDLE);
    assign dbg_state      = r_state;

endmodule
